// File: rtl/event_arbiter_rr.sv
// Round-robin arbiter moving one event at a time from per-channel local FIFOs to the shared FIFO.
// Optional even-parity bit in event_out[WIDTH-1] when EVENT_ARB_PARITY_EN is defined.
module event_arbiter_rr #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned NUMCHANNELS = 64,
  parameter int unsigned CHW         = $clog2(NUMCHANNELS)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUMCHANNELS-1:0][WIDTH-2:0]    input_event,
  input  logic [NUMCHANNELS-1:0]               local_fifo_empty,
  output logic [NUMCHANNELS-1:0]               read_local_fifo_n,
  input  logic                                 fifo_full,
  output logic                                 write_fifo_n,
  output logic [WIDTH-1:0]                     event_out,
  output logic [CHW-1:0]                       grant_channel,
  output logic                                 busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [CHW-1:0]         r_ptr;
  logic [CHW-1:0]         w_ptr_nxt;
  logic [CHW-1:0]         r_grant;
  logic [CHW-1:0]         w_grant_nxt;
  logic [CHW-1:0]         w_ptr_adv;
  logic [CHW-1:0]         w_base;
  logic [CHW-1:0]         w_pick;
  logic                   w_any;
  int unsigned            w_idx;
  logic [NUMCHANNELS-1:0] w_req;
  logic [NUMCHANNELS-1:0] r_rd_n;
  logic [NUMCHANNELS-1:0] w_rd_n_nxt;
  logic [WIDTH-1:0]       r_event;
  logic [WIDTH-1:0]       w_event_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;
  logic                   w_write_n;

  assign w_req     = ~local_fifo_empty;
  assign w_ptr_adv = (r_grant == CHW'(NUMCHANNELS - 1)) ? '0 : r_grant + CHW'(1);
  // In WRITE the next grant is searched from the pointer as it will be after this write.
  assign w_base    = (r_state == S_WRITE) ? w_ptr_adv : r_ptr;

  // First requester at or after w_base, wrapping.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = 0;
    for (int unsigned i = 0; i < NUMCHANNELS; i++) begin
      w_idx = (32'(w_base) + i) % NUMCHANNELS;
      if (!w_any && w_req[CHW'(w_idx)]) begin
        w_any  = 1'b1;
        w_pick = CHW'(w_idx);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_event_nxt = r_event;
    w_write_n   = 1'b1;
    w_rd_n_nxt  = '1;
    w_busy_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_pick;
          w_state_nxt = S_READ;
        end
      end
      S_READ: w_state_nxt = S_LATCH;
      S_LATCH: begin
`ifdef EVENT_ARB_PARITY_EN
        w_event_nxt = {^input_event[r_grant], input_event[r_grant]};
`else
        w_event_nxt = {1'b0, input_event[r_grant]};
`endif
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (!fifo_full) begin
          w_write_n = 1'b0;
          w_ptr_nxt = w_ptr_adv;
          if (w_any) begin
            w_grant_nxt = w_pick;
            w_state_nxt = S_READ;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt == S_READ) w_rd_n_nxt[w_grant_nxt] = 1'b0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_event <= '0;
      r_rd_n  <= '1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_event <= w_event_nxt;
      r_rd_n  <= w_rd_n_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign read_local_fifo_n = r_rd_n;
  assign write_fifo_n      = w_write_n;
  assign event_out         = r_event;
  assign grant_channel     = r_grant;
  assign busy              = r_busy;

endmodule
